// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32I core.
// Owns the PC, issues reads to a 1-cycle-latency synchronous instruction
// memory and drives the IF/ID pipeline register. A one-entry skid buffer
// catches the word returning from imem while ID is frozen, so nothing is
// lost or refetched across a stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    STALL_EMPTY = 2'd1,
    STALL_FULL  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic        resp_valid_q;
  logic [31:0] resp_pc_q;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic [31:0] target_pc;

  // The skid occupancy flag is the STALL_FULL state itself, so the two
  // can never disagree.
  assign skid_valid = (state == STALL_FULL);

  // Word-aligned redirect target; the low two address bits are dropped.
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  // Fetch request: address is the PC, strobe only when ID can advance.
  assign imem_addr = pc_q;
  assign imem_rd   = rst_n & ~stall & ~redirect;

  // PC, response tracking, skid buffer, IF/ID register and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      skid_pc      <= '0;
      skid_inst    <= '0;
      id_pc        <= '0;
      id_inst      <= NOP_INST;
      id_valid     <= 1'b0;
    end else if (redirect) begin
      // Flush everything in flight; id_pc is left holding its old value.
      pc_q         <= target_pc;
      resp_valid_q <= 1'b0;
      id_valid     <= 1'b0;
      id_inst      <= NOP_INST;
      state        <= stall ? STALL_EMPTY : RUN;
    end else if (stall) begin
      resp_valid_q <= 1'b0;
      if (resp_valid_q) begin
        skid_pc   <= resp_pc_q;
        skid_inst <= imem_rdata;
        state     <= STALL_FULL;
      end else if (state != STALL_FULL) begin
        state <= STALL_EMPTY;
      end
    end else begin
      pc_q         <= pc_q + 32'd4;
      resp_valid_q <= 1'b1;
      resp_pc_q    <= pc_q;
      state        <= RUN;
      if (skid_valid) begin
        id_pc    <= skid_pc;
        id_inst  <= skid_inst;
        id_valid <= 1'b1;
      end else begin
        id_pc    <= resp_pc_q;
        id_inst  <= resp_valid_q ? imem_rdata : NOP_INST;
        id_valid <= resp_valid_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: imem model returns 0x100 + address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  // Second instance with a PC near the top of the address space.
  logic [31:0] imem_addr2;
  logic        imem_rd2;
  logic [31:0] imem_rdata2;
  logic [31:0] id_pc2;
  logic [31:0] id_inst2;
  logic        id_valid2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_rdata  (imem_rdata),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_valid    (id_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INST(32'h0000_0013)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .imem_addr   (imem_addr2),
    .imem_rd     (imem_rd2),
    .imem_rdata  (imem_rdata2),
    .id_pc       (id_pc2),
    .id_inst     (id_inst2),
    .id_valid    (id_valid2)
  );

  // Synchronous instruction memories: mem[a] = 0x100 + a.
  always @(posedge clk) begin
    if (imem_rd)  imem_rdata  <= 32'h100 + imem_addr;
    if (imem_rd2) imem_rdata2 <= 32'h100 + imem_addr2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] inst);
    check({tag, "_valid"}, {31'b0, id_valid}, {31'b0, v});
    check({tag, "_pc"}, id_pc, pc);
    check({tag, "_inst"}, id_inst, inst);
  endtask

  // Invariant: an outstanding response and a full skid never coexist.
  always @(negedge clk) begin
    if (rst_n === 1'b1)
      check("resp_and_skid", {31'b0, dut.resp_valid_q & dut.skid_valid}, 32'd0);
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #12;
    // Reset values
    check("rst_rd", {31'b0, imem_rd}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check_id("rst_id", 1'b0, 32'h0, 32'h13);
    check("rst_addr2", imem_addr2, 32'hFFFF_FFF8);
    check("rst_rd2", {31'b0, imem_rd2}, 32'd0);
    check("rst_id2_valid", {31'b0, id_valid2}, 32'd0);
    check("rst_id2_inst", id_inst2, 32'h13);
    check("rst_id2_pc", id_pc2, 32'h0);

    tick();
    rst_n = 1'b1;
    // cycle 0
    #1;
    check("c0_addr", imem_addr, 32'h0);
    check("c0_rd", {31'b0, imem_rd}, 32'd1);
    check("c0_addr2", imem_addr2, 32'hFFFF_FFF8);
    tick(); // cycle 1
    check("c1_addr", imem_addr, 32'h4);
    check("c1_idv", {31'b0, id_valid}, 32'd0);
    check("c1_addr2", imem_addr2, 32'hFFFF_FFFC);
    tick(); // cycle 2
    check("c2_addr", imem_addr, 32'h8);
    check_id("c2_id", 1'b1, 32'h0, 32'h100);
    check("c2_addr2", imem_addr2, 32'h0);
    check("c2_id2_pc", id_pc2, 32'hFFFF_FFF8);
    check("c2_id2_inst", id_inst2, 32'h0000_00F8);
    check("c2_id2_valid", {31'b0, id_valid2}, 32'd1);
    tick(); // cycle 3: word for pc 8 returning
    check_id("c3_id", 1'b1, 32'h4, 32'h104);

    // Three-cycle stall while pc 8 returns
    stall = 1'b1;
    #1;
    check("st_rd", {31'b0, imem_rd}, 32'd0);
    tick(); // cycle 4
    check("skid_v", {31'b0, dut.skid_valid}, 32'd1);
    check("skid_pc", dut.skid_pc, 32'h8);
    check("skid_inst", dut.skid_inst, 32'h108);
    check_id("st1_id", 1'b1, 32'h4, 32'h104);
    check("st1_addr", imem_addr, 32'hC);
    tick(); // cycle 5
    check_id("st2_id", 1'b1, 32'h4, 32'h104);
    tick(); // cycle 6: release
    stall = 1'b0;
    #1;
    check("rel_rd", {31'b0, imem_rd}, 32'd1);
    check("rel_addr", imem_addr, 32'hC);
    tick(); // cycle 7
    check_id("rel1_id", 1'b1, 32'h8, 32'h108);
    tick(); // cycle 8
    check_id("rel2_id", 1'b1, 32'hC, 32'h10C);

    // Plain redirect, then single-cycle stall with no response pending
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    check("rd1_rd", {31'b0, imem_rd}, 32'd0);
    tick(); // cycle 9
    redirect = 1'b0;
    check_id("rd1_flush", 1'b0, 32'hC, 32'h13);
    check("rd1_addr", imem_addr, 32'h40);
    stall = 1'b1;
    tick(); // cycle 10
    stall = 1'b0;
    check("ss_skid", {31'b0, dut.skid_valid}, 32'd0);
    check("ss_addr", imem_addr, 32'h40);
    tick(); // cycle 11
    check("ss_idv", {31'b0, id_valid}, 32'd0);
    tick(); // cycle 12
    check_id("ss1_id", 1'b1, 32'h40, 32'h140);
    tick(); // cycle 13
    check_id("ss2_id", 1'b1, 32'h44, 32'h144);

    // Fill skid, then redirect while stalled
    stall = 1'b1;
    tick(); // cycle 14
    check("fs_skid", {31'b0, dut.skid_valid}, 32'd1);
    check("fs_skid_pc", dut.skid_pc, 32'h48);
    redirect = 1'b1; redirect_pc = 32'h203;
    #1;
    check("rd2_rd", {31'b0, imem_rd}, 32'd0);
    tick(); // cycle 15
    stall = 1'b0; redirect = 1'b0;
    check_id("rd2_flush", 1'b0, 32'h44, 32'h13);
    check("rd2_skid", {31'b0, dut.skid_valid}, 32'd0);
    check("rd2_addr", imem_addr, 32'h200);
    #1;
    check("rd2_issue", {31'b0, imem_rd}, 32'd1);
    tick(); // cycle 16
    check("rd2_idv", {31'b0, id_valid}, 32'd0);
    tick(); // cycle 17
    check_id("rd2_tgt", 1'b1, 32'h200, 32'h300);

    // Async reset while STALL_FULL
    stall = 1'b1;
    tick(); // cycle 18
    check("rs_skid", {31'b0, dut.skid_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_id("rs_id", 1'b0, 32'h0, 32'h13);
    check("rs_addr", imem_addr, 32'h0);
    check("rs_rd", {31'b0, imem_rd}, 32'd0);
    check("rs_skid0", {31'b0, dut.skid_valid}, 32'd0);
    tick();
    stall = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rs1_idv", {31'b0, id_valid}, 32'd0);
    tick();
    check_id("rs2_id", 1'b1, 32'h0, 32'h100);
    tick();
    check_id("rs3_id", 1'b1, 32'h4, 32'h104);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage RV32I core: owns the PC, issues reads to the synchronous instruction memory (1-cycle read latency) and drives the IF/ID pipeline register.
- Consumes the decode-stage stall from the hazard/stall logic and the taken-branch/jump redirect.
- Contains a one-entry skid buffer, so an instruction returned by imem while ID is frozen is never lost or refetched.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on id_inst when id_valid=0.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset. Deassertion is synchronised upstream.
- stall  in  1  freeze ID: hold id_* and pc_q (OR of branch stall and load-use stall).
- redirect  in  1  taken branch/jump resolved in ID. Has priority over stall.
- redirect_pc  in  32  target address. Bits [1:0] are ignored and forced to 0.
- imem_addr  out  32  fetch address, equal to pc_q.
- imem_rd  out  1  read strobe. Data for the sampled address appears on imem_rdata next cycle.
- imem_rdata  in  32  instruction data, valid the cycle after imem_rd=1.
- id_pc  out  32  PC of the instruction in ID.
- id_inst  out  32  instruction in ID.
- id_valid  out  1  id_inst is real (1) or a bubble (0).

Behaviour:
- State: pc_q, resp_valid_q/resp_pc_q (a request issued last cycle has data on imem_rdata now), skid_valid/skid_pc/skid_inst, id_pc/id_inst/id_valid.
- FSM over (stall, skid_valid) has three states:
  - RUN: no stall.
  - STALL_EMPTY: stalled, skid empty.
  - STALL_FULL: stalled, skid holds an instruction.
- Reset (async): pc_q=RESET_PC, resp_valid_q=0, skid_valid=0, id_valid=0, id_inst=NOP_INST, id_pc=0, state RUN.
- Outputs during reset: imem_rd=0 while rst_n=0. imem_addr=RESET_PC.
- imem_rd = ~stall & ~redirect (combinational). imem_addr = pc_q.
- RUN (stall=0, redirect=0):
  - pc_q += 4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
  - resp_valid_q<=1, resp_pc_q<=pc_q.
  - If skid_valid: ID loads skid_pc/skid_inst with id_valid=1, and skid_valid<=0.
  - Else: ID loads resp_pc_q/imem_rdata with id_valid<=resp_valid_q. If resp_valid_q=0, id_inst<=NOP_INST.
- Stall (stall=1, redirect=0):
  - id_* and pc_q hold. resp_valid_q<=0.
  - If resp_valid_q=1, the returning word is captured: skid_inst<=imem_rdata, skid_pc<=resp_pc_q, skid_valid<=1. Transition to STALL_FULL.
  - Otherwise the state is STALL_EMPTY, or STALL_FULL is kept.
  - resp_valid_q=1 and skid_valid=1 simultaneously cannot occur. The bench must assert this never happens.
- Stall release: the first RUN cycle drains the skid (if full) and reissues pc_q. The instruction following the drained one enters ID exactly one cycle later. No duplicates, no gaps.
- Redirect (regardless of stall):
  - pc_q<={redirect_pc[31:2],2'b00}.
  - resp_valid_q<=0, skid_valid<=0, id_valid<=0, id_inst<=NOP_INST. id_pc holds.
  - imem_rd=0 in the redirect cycle. The target is issued in the next cycle.
  - The first target instruction reaches ID 2 cycles after the redirect edge.
- Latency: from a fetch issue (imem_rd=1 at cycle n), the instruction appears in ID at cycle n+2.
- Async reset asserted mid-stall or mid-redirect clears all state immediately. Nothing pending survives.

Test Plan:
- Reset release, imem returns mem[a]=0x100+a, no stall:
  - imem_addr goes 0,4,8,… with imem_rd=1 from cycle 0.
  - id_valid=1 first at cycle 2, with id_pc=0, id_inst=0x100. Then id_pc advances +4 per cycle.
- stall=1 for 3 cycles while the instruction at pc 8 is returning:
  - id holds pc 4, imem_rd=0, skid captures (8, 0x108).
  - On release, ID shows pc 8 then pc 12 on consecutive cycles. No repeated or missing PC.
- Single-cycle stall with resp_valid_q=0 (right after a redirect): no skid capture. After release the sequence is unchanged.
- redirect=1 with redirect_pc=0x203 while stall=1 and skid full:
  - skid is discarded and id_valid=0 with id_inst=0x13.
  - imem_addr=0x200 next cycle. ID shows pc 0x200 two cycles after the redirect edge.
- RESET_PC=0xFFFF_FFF8: fetch addresses run FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n pulsed low while in STALL_FULL: all outputs go to reset values immediately. The first ID instruction after release is at RESET_PC.
